// File: rtl/seg7_pkg.sv
// Shared constants and types for the seven-segment scan controller:
// hex segment codes, all-off patterns, digit limits and the display word.
package seg7_pkg;

    // Hard upper limit on scanned digits; the host word is always 8 nibbles.
    localparam int MAX_DIGITS = 8;
    localparam int MAX_IDX_W  = 3;

    // All-off patterns in the active-high view; polarity is applied at the pins.
    localparam logic [7:0] SEG_OFF = 8'h00;
    localparam logic [7:0] AN_OFF  = 8'h00;

    // Active-high {g,f,e,d,c,b,a} codes for hex digits 0..F.
    localparam logic [6:0] HEX_SEG [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    // One complete display image: nibbles, decimal points and digit enables.
    typedef struct packed {
        logic [MAX_DIGITS-1:0][3:0] data;
        logic [MAX_DIGITS-1:0]      dp;
        logic [MAX_DIGITS-1:0]      en;
    } disp_word_t;

    // Converts an active-high pattern to the pin polarity.
    function automatic logic [7:0] apply_polarity(input logic [7:0] v, input bit act_low);
        return act_low ? ~v : v;
    endfunction

endpackage

// File: rtl/seg7_scan_ctrl_if.sv
// Host/display bundle for the scan controller: scan tick, load strobe with
// its data word, and the segment/anode/frame outputs.
interface seg7_scan_ctrl_if;
    import seg7_pkg::*;

    logic                      scan_clk;
    logic                      load;
    logic [4*MAX_DIGITS-1:0]   data_in;
    logic [MAX_DIGITS-1:0]     dp_in;
    logic [MAX_DIGITS-1:0]     en_in;
    logic [7:0]                seg_out;
    logic [7:0]                an_out;
    logic                      frame_done;

    // Host side: drives the tick and the load word, observes the display.
    modport master (
        output scan_clk, load, data_in, dp_in, en_in,
        input  seg_out, an_out, frame_done
    );

    // Controller side.
    modport slave (
        input  scan_clk, load, data_in, dp_in, en_in,
        output seg_out, an_out, frame_done
    );

endinterface

// File: rtl/hex_to_seg7.sv
// Combinational hex decoder: nibble plus decimal point to an active-high
// {dp,g,f,e,d,c,b,a} pattern. Pin polarity is handled by the caller.
module hex_to_seg7
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       dp,
    output logic [7:0] code
);

    // Table lookup with the decimal point on bit 7.
    always_comb begin
        code = {dp, HEX_SEG[nibble]};
    end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed seven-segment scan controller. A rising edge of scan_clk
// (sampled in the clk domain) advances one digit. The host word is held in a
// shadow register and copied to the displayed word only when the digit index
// wraps, so a frame never mixes old and new data.
module seg7_scan_ctrl
    import seg7_pkg::*;
#(
    parameter int DIGITS      = 8,
    parameter bit SEG_ACT_LOW = 1'b1,
    parameter bit AN_ACT_LOW  = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    seg7_scan_ctrl_if.slave    bus
);

    localparam int                IDX_W    = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(DIGITS - 1);
    localparam logic [7:0]        SEG_RST  = apply_polarity(SEG_OFF, SEG_ACT_LOW);
    localparam logic [7:0]        AN_RST   = apply_polarity(AN_OFF, AN_ACT_LOW);

    // Scan-tick edge detector and digit index.
    logic                  sc_q, sc_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic                  strobe;
    logic                  wrap;

    // Double buffer: host writes shadow, frame wrap moves it to active.
    disp_word_t            shadow_q, shadow_d;
    disp_word_t            active_q, active_d;
    logic                  pending_q, pending_d;

    // Registered outputs.
    logic                  frame_done_q, frame_done_d;
    logic [7:0]            seg_q, seg_d;
    logic [7:0]            an_q, an_d;

    // Current scan slot as seen by the output stage.
    logic [MAX_IDX_W-1:0]  idx_ext;
    logic [3:0]            cur_nibble;
    logic                  cur_dp;
    logic                  cur_en;
    logic [7:0]            cur_code;
    logic [7:0]            seg_hi;
    logic [7:0]            an_hi;

    // Edge detect, index advance/wrap and shadow/active/pending update.
    always_comb begin
        // NOTE: every _d takes its hold value first, so no path through this block can infer a latch.
        sc_d         = bus.scan_clk;
        idx_d        = idx_q;
        shadow_d     = shadow_q;
        active_d     = active_q;
        pending_d    = pending_q;
        frame_done_d = 1'b0;

        strobe = bus.scan_clk & ~sc_q;
        wrap   = strobe && (idx_q == LAST_IDX);

        if (strobe) begin
            if (wrap) begin
                idx_d        = '0;
                frame_done_d = 1'b1;
                // Only a word that was already waiting is promoted; a load in
                // this same cycle lands in shadow and waits one more frame.
                if (pending_q) begin
                    active_d  = shadow_q;
                    pending_d = 1'b0;
                end
            end else begin
                idx_d = idx_q + IDX_W'(1);
            end
        end

        // Later loads within a frame simply overwrite the shadow word.
        if (bus.load) begin
            shadow_d  = {bus.data_in, bus.dp_in, bus.en_in};
            pending_d = 1'b1;
        end
    end

    // Select the nibble, dp and enable for the digit currently being scanned.
    always_comb begin
        idx_ext    = MAX_IDX_W'(idx_q);
        cur_nibble = active_q.data[idx_ext];
        cur_dp     = active_q.dp[idx_ext];
        cur_en     = active_q.en[idx_ext];
    end

    hex_to_seg7 u_hex_to_seg7 (
        .nibble (cur_nibble),
        .dp     (cur_dp),
        .code   (cur_code)
    );

    // Output stage: one-hot anode and decoded segments, blanked slots fully dark.
    always_comb begin
        seg_hi = SEG_OFF;
        an_hi  = AN_OFF;
        if (cur_en) begin
            seg_hi = cur_code;
            an_hi  = 8'h01 << idx_ext;
        end
        seg_d = apply_polarity(seg_hi, SEG_ACT_LOW);
        an_d  = apply_polarity(an_hi, AN_ACT_LOW);
    end

    // State and output registers with immediate asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sc_q         <= 1'b0;
            idx_q        <= '0;
            // NOTE: the shadow and active words are reset like any other flop so the display is defined from the first frame.
            shadow_q     <= '0;
            active_q     <= '0;
            pending_q    <= 1'b0;
            frame_done_q <= 1'b0;
            seg_q        <= SEG_RST;
            an_q         <= AN_RST;
        end else begin
            // NOTE: non-blocking assignments so every register samples the pre-edge values.
            sc_q         <= sc_d;
            idx_q        <= idx_d;
            shadow_q     <= shadow_d;
            active_q     <= active_d;
            pending_q    <= pending_d;
            frame_done_q <= frame_done_d;
            seg_q        <= seg_d;
            an_q         <= an_d;
        end
    end

    assign bus.seg_out    = seg_q;
    assign bus.an_out     = an_q;
    assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed bench for seg7_scan_ctrl: an 8-digit and a 4-digit build share one
// stimulus stream; a reference model pushes expected outputs to a scoreboard
// that is popped when the DUT output is due.
module tb_seg7_scan_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    seg7_scan_ctrl_if if8 ();
    seg7_scan_ctrl_if if4 ();

    seg7_scan_ctrl #(.DIGITS(8), .SEG_ACT_LOW(1'b1), .AN_ACT_LOW(1'b1)) dut8 (
        .clk (clk),
        .rst (rst),
        .bus (if8)
    );

    seg7_scan_ctrl #(.DIGITS(4), .SEG_ACT_LOW(1'b1), .AN_ACT_LOW(1'b1)) dut4 (
        .clk (clk),
        .rst (rst),
        .bus (if4)
    );

    assign if4.scan_clk = if8.scan_clk;
    assign if4.load     = if8.load;
    assign if4.data_in  = if8.data_in;
    assign if4.dp_in    = if8.dp_in;
    assign if4.en_in    = if8.en_in;

    localparam logic [6:0] HEX_REF [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    // Reference model, index 0 = 8-digit build, 1 = 4-digit build.
    int          digits [2] = '{8, 4};
    int          m_idx [2];
    logic [31:0] m_a_data [2];
    logic [7:0]  m_a_dp [2];
    logic [7:0]  m_a_en [2];
    logic [31:0] m_s_data [2];
    logic [7:0]  m_s_dp [2];
    logic [7:0]  m_s_en [2];
    bit          m_pend [2];
    bit          m_fd [2];
    int          m_fd_count [2];
    int          o_fd_count [2];
    logic [7:0]  m_last_seg [2];
    logic [7:0]  m_last_an [2];

    typedef struct {
        int         inst;
        logic [7:0] seg;
        logic [7:0] an;
    } exp_t;

    exp_t sb [$];

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] obs_seg(input int i);
        return (i == 0) ? if8.seg_out : if4.seg_out;
    endfunction

    function automatic logic [7:0] obs_an(input int i);
        return (i == 0) ? if8.an_out : if4.an_out;
    endfunction

    function automatic logic [7:0] obs_fd(input int i);
        return (i == 0) ? 8'(if8.frame_done) : 8'(if4.frame_done);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_idx[i]      = 0;
            m_a_data[i]   = '0;
            m_a_dp[i]     = '0;
            m_a_en[i]     = '0;
            m_s_data[i]   = '0;
            m_s_dp[i]     = '0;
            m_s_en[i]     = '0;
            m_pend[i]     = 1'b0;
            m_fd[i]       = 1'b0;
            m_last_seg[i] = 8'hFF;
            m_last_an[i]  = 8'hFF;
        end
    endtask

    task automatic model_load(input logic [31:0] d, input logic [7:0] dp, input logic [7:0] en);
        for (int i = 0; i < 2; i++) begin
            m_s_data[i] = d;
            m_s_dp[i]   = dp;
            m_s_en[i]   = en;
            m_pend[i]   = 1'b1;
        end
    endtask

    task automatic model_strobe(input bit ld, input logic [31:0] d, input logic [7:0] dp,
                                input logic [7:0] en);
        for (int i = 0; i < 2; i++) begin
            m_fd[i] = (m_idx[i] == digits[i] - 1);
            if (m_fd[i]) begin
                m_idx[i] = 0;
                m_fd_count[i]++;
                if (m_pend[i]) begin
                    m_a_data[i] = m_s_data[i];
                    m_a_dp[i]   = m_s_dp[i];
                    m_a_en[i]   = m_s_en[i];
                    m_pend[i]   = 1'b0;
                end
            end else begin
                m_idx[i]++;
            end
        end
        if (ld) model_load(d, dp, en);
    endtask

    task automatic push_expect();
        for (int i = 0; i < 2; i++) begin
            exp_t       e;
            logic [3:0] nib;
            logic [7:0] code;
            e.inst = i;
            if (m_a_en[i][m_idx[i]]) begin
                nib   = m_a_data[i][4*m_idx[i] +: 4];
                code  = {m_a_dp[i][m_idx[i]], HEX_REF[nib]};
                e.seg = ~code;
                e.an  = ~(8'h01 << m_idx[i]);
            end else begin
                e.seg = 8'hFF;
                e.an  = 8'hFF;
            end
            sb.push_back(e);
        end
    endtask

    task automatic compare_outputs(input string tag);
        for (int i = 0; i < 2; i++) begin
            exp_t e;
            if (sb.size() == 0) begin
                check($sformatf("%s_sb_empty", tag), 8'h00, 8'h01);
            end else begin
                e = sb.pop_front();
                check($sformatf("%s_seg_d%0d", tag, digits[e.inst]), obs_seg(e.inst), e.seg);
                check($sformatf("%s_an_d%0d", tag, digits[e.inst]), obs_an(e.inst), e.an);
                m_last_seg[e.inst] = e.seg;
                m_last_an[e.inst]  = e.an;
            end
        end
    endtask

    task automatic do_load(input logic [31:0] d, input logic [7:0] dp, input logic [7:0] en);
        if8.load    = 1'b1;
        if8.data_in = d;
        if8.dp_in   = dp;
        if8.en_in   = en;
        model_load(d, dp, en);
        @(negedge clk);
        if8.load = 1'b0;
    endtask

    // One scan tick: rise, check the frame pulse, fall, then check the output slot.
    task automatic advance(input string tag, input bit ld = 1'b0, input logic [31:0] d = '0,
                           input logic [7:0] dp = '0, input logic [7:0] en = '0);
        if8.scan_clk = 1'b1;
        if (ld) begin
            if8.load    = 1'b1;
            if8.data_in = d;
            if8.dp_in   = dp;
            if8.en_in   = en;
        end
        model_strobe(ld, d, dp, en);
        push_expect();
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            check($sformatf("%s_fd_d%0d", tag, digits[i]), obs_fd(i), 8'(m_fd[i]));
            if (obs_fd(i) == 8'h01) o_fd_count[i]++;
            check($sformatf("%s_lat_seg_d%0d", tag, digits[i]), obs_seg(i), m_last_seg[i]);
        end
        if8.scan_clk = 1'b0;
        if8.load     = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 2; i++)
            check($sformatf("%s_fd_off_d%0d", tag, digits[i]), obs_fd(i), 8'h00);
        compare_outputs(tag);
    endtask

    task automatic check_fd_counts(input string tag);
        for (int i = 0; i < 2; i++) begin
            check($sformatf("%s_fdcnt_d%0d", tag, digits[i]), 8'(o_fd_count[i]), 8'(m_fd_count[i]));
            o_fd_count[i] = 0;
            m_fd_count[i] = 0;
        end
    endtask

    task automatic check_off(input string tag);
        for (int i = 0; i < 2; i++) begin
            check($sformatf("%s_seg_d%0d", tag, digits[i]), obs_seg(i), 8'hFF);
            check($sformatf("%s_an_d%0d", tag, digits[i]), obs_an(i), 8'hFF);
            check($sformatf("%s_fd_d%0d", tag, digits[i]), obs_fd(i), 8'h00);
        end
    endtask

    initial begin
        if8.scan_clk = 1'b0;
        if8.load     = 1'b0;
        if8.data_in  = '0;
        if8.dp_in    = '0;
        if8.en_in    = '0;
        model_reset();
        for (int i = 0; i < 2; i++) begin
            m_fd_count[i] = 0;
            o_fd_count[i] = 0;
        end

        // Reset state, then release; active word is all zero so slots are blank.
        repeat (3) @(negedge clk);
        check_off("reset");
        rst = 1'b0;
        @(negedge clk);
        check_off("post_reset");

        // Hex pattern: first frame still blank, second frame shows 0..7.
        do_load(32'h7654_3210, 8'h00, 8'hFF);
        repeat (16) advance("t2");
        check_fd_counts("t2");

        // Asynchronous reset mid-frame: outputs go dark with no clock edge.
        repeat (3) advance("t1_pre");
        #2 rst = 1'b1;
        #1 check_off("t1_async");
        @(negedge clk);
        check_off("t1_held");
        rst = 1'b0;
        model_reset();
        for (int i = 0; i < 2; i++) begin
            m_fd_count[i] = 0;
            o_fd_count[i] = 0;
        end
        repeat (8) advance("t1_restart");
        do_load(32'h7654_3210, 8'h00, 8'hFF);
        repeat (16) advance("t1_reload");
        check_fd_counts("t1");

        // Partially enabled word of all F.
        do_load(32'hFFFF_FFFF, 8'h00, 8'h0F);
        repeat (16) advance("t3");

        // Decimal points on alternating digits.
        do_load(32'h89AB_CDEF, 8'hA5, 8'hFF);
        repeat (16) advance("t3_dp");

        // Two loads in one frame: only the last one is displayed.
        do_load(32'h1111_1111, 8'h00, 8'hFF);
        repeat (3) advance("t4_a");
        do_load(32'h2222_2222, 8'h00, 8'hFF);
        repeat (13) advance("t4_b");

        // Load coinciding with the wrap strobe while nothing is pending.
        repeat (7) advance("t4_c");
        advance("t4_wrapload", 1'b1, 32'h3333_3333, 8'h00, 8'hFF);
        repeat (16) advance("t4_d");
        check_fd_counts("t4");

        // scan_clk held high: one advance only, display frozen but driven.
        if8.scan_clk = 1'b1;
        model_strobe(1'b0, '0, '0, '0);
        push_expect();
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            check($sformatf("t5_fd_d%0d", digits[i]), obs_fd(i), 8'(m_fd[i]));
            if (obs_fd(i) == 8'h01) o_fd_count[i]++;
            check($sformatf("t5_lat_seg_d%0d", digits[i]), obs_seg(i), m_last_seg[i]);
            check($sformatf("t5_lat_an_d%0d", digits[i]), obs_an(i), m_last_an[i]);
        end
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (c % 25 == 24) begin
                for (int k = 0; k < 2; k++) begin
                    check($sformatf("t5_hold_seg_d%0d", digits[sb[k].inst]), obs_seg(sb[k].inst), sb[k].seg);
                    check($sformatf("t5_hold_an_d%0d", digits[sb[k].inst]), obs_an(sb[k].inst), sb[k].an);
                    check($sformatf("t5_hold_fd_d%0d", digits[sb[k].inst]), obs_fd(sb[k].inst), 8'h00);
                end
            end
        end
        compare_outputs("t5_hold");
        if8.scan_clk = 1'b0;
        @(negedge clk);
        repeat (7) advance("t5_after");
        check_fd_counts("t6");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
